// File: rtl/seno_pkg.sv
// Shared types and default sizing for the sine-table sample player.
// Quarter-wave table folding is selected by SENO_QUARTER_WAVE_EN.
package seno_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
  localparam int PHASE_W_DEF = 32;
  localparam int DIV_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FETCH,
    CAPTURE,
    HOLD
  } state_t;

  // Top two address bits: which quarter of the full wave is being played.
  typedef logic [1:0] quad_t;

endpackage

// File: rtl/seno_tick_gen.sv
// Sample-rate divider: one-cycle tick every clk_div+1 cycles while enabled.
// Held cleared while enable is low so the first tick after enable is deterministic.
module seno_tick_gen
  import seno_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    tick      = enable && (div_cnt_q == clk_div);
    div_cnt_d = div_cnt_q + 1'b1;
    if (!enable || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/seno_sample_player.sv
// DDS sample player: phase accumulator drives sine-table reads, samples leave on a stream port.
// Define SENO_QUARTER_WAVE_EN for a first-quadrant table with address/sign folding.
module seno_sample_player
  import seno_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [DIV_W-1:0]   clk_div,
  output logic               ram_en,
`ifdef SENO_QUARTER_WAVE_EN
  output logic [ADDR_W-3:0]  ram_addr,
`else
  output logic [ADDR_W-1:0]  ram_addr,
`endif
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               overrun
);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               overrun_q, overrun_d;
  logic [DATA_W-1:0]  sample;
  logic               tick;

  seno_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .enable  (enable),
    .clk_div (clk_div),
    .tick    (tick)
  );

`ifdef SENO_QUARTER_WAVE_EN
  quad_t             quad_q, quad_d;
  logic [ADDR_W-3:0] idx;

  assign idx      = addr_q[ADDR_W-3:0];
  assign ram_addr = addr_q[ADDR_W-2] ? ~idx : idx;
  // Quadrant travels with the read so the sign matches the data returned.
  assign quad_d   = (state_q == FETCH) ? addr_q[ADDR_W-1 -: 2] : quad_q;
  assign sample   = quad_q[1] ? -ram_rdata : ram_rdata;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      quad_q <= '0;
    end else begin
      quad_q <= quad_d;
    end
  end
`else
  assign ram_addr = addr_q;
  assign sample   = ram_rdata;
`endif

  assign ram_en   = (state_q == FETCH);
  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;

    // Phase keeps advancing on dropped ticks so the output frequency is preserved.
    if (!enable) begin
      phase_d   = '0;
      overrun_d = 1'b0;
    end else if (tick && (state_q != IDLE)) begin
      phase_d = phase_q + phase_inc;
      if (state_q != WAIT) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        tdata_d  = sample;
        tvalid_d = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (m_tready) begin
          tvalid_d = 1'b0;
          state_d  = enable ? WAIT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      addr_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_seno_sample_player.sv
// Self-checking bench for seno_sample_player: cycle model feeds a sample scoreboard.
// Expectations follow SENO_QUARTER_WAVE_EN when it is defined.
module tb_seno_sample_player;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] phase_inc = '0;
  logic [15:0] clk_div = '0;
  logic        ram_en;
`ifdef SENO_QUARTER_WAVE_EN
  logic [7:0]  ram_addr;
`else
  logic [9:0]  ram_addr;
`endif
  logic [15:0] ram_rdata = '0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int nsamp = 0;
  bit chk_on = 1'b0;

  logic [15:0] sb[$];
  logic [15:0] acc[$];

  always #5 ACLK = ~ACLK;

  seno_sample_player dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .enable    (enable),
    .phase_inc (phase_inc),
    .clk_div   (clk_div),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Table contents: ramp in quarter-wave mode, distinct affine pattern otherwise.
  function automatic logic [15:0] rom(input logic [9:0] i);
    logic [31:0] t;
`ifdef SENO_QUARTER_WAVE_EN
    t = {24'h0, i[7:0]};
`else
    t = 32'(i) * 97 + 32'h1234;
`endif
    return t[15:0];
  endfunction

  function automatic logic [9:0] fold_addr(input logic [9:0] a);
`ifdef SENO_QUARTER_WAVE_EN
    logic [7:0] idx;
    idx = a[8] ? ~a[7:0] : a[7:0];
    return {2'b00, idx};
`else
    return a;
`endif
  endfunction

  function automatic logic [15:0] exp_data(input logic [9:0] a);
    logic [15:0] d;
    d = rom(fold_addr(a));
`ifdef SENO_QUARTER_WAVE_EN
    if (a[9]) d = -d;
`endif
    return d;
  endfunction

  always @(posedge ACLK) begin
    if (ram_en) ram_rdata <= rom({2'b00, ram_addr} & 10'h3FF);
  end

  // Reference cycle model of the player, driven only by bench inputs.
  int          mst;
  logic [15:0] mcnt;
  logic [31:0] mph, ph_old;
  logic        mtick;
  logic        e_ram_en, e_valid, e_overrun;
  logic [9:0]  e_addr;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      mst = 0; mcnt = '0; mph = '0; e_addr = '0;
      e_ram_en = 1'b0; e_valid = 1'b0; e_overrun = 1'b0;
      sb.delete();
    end else begin
      mtick = enable && (mcnt == clk_div);
      mcnt  = (!enable || mtick) ? 16'd0 : mcnt + 16'd1;
      if (!enable) e_overrun = 1'b0;
      else if (mtick && mst >= 2) e_overrun = 1'b1;
      ph_old = mph;
      if (!enable) mph = '0;
      else if (mtick && mst != 0) mph = mph + phase_inc;
      case (mst)
        0: if (enable) mst = 1;
        1: if (!enable) mst = 0;
           else if (mtick) begin
             e_addr = fold_addr(ph_old[31:22]);
             sb.push_back(exp_data(ph_old[31:22]));
             mst = 2;
           end
        2: mst = 3;
        3: mst = 4;
        4: if (m_tready) mst = enable ? 1 : 0;
        default: mst = 0;
      endcase
      e_ram_en = (mst == 2);
      e_valid  = (mst == 4);
    end
  end

  always @(negedge ACLK) begin
    if (chk_on) begin
      check("ram_en", ram_en, e_ram_en);
      check("m_tvalid", m_tvalid, e_valid);
      check("overrun", overrun, e_overrun);
      if (e_ram_en) check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (m_tvalid) begin
        if (sb.size() == 0) begin
          check("sb_level", sb.size(), 1);
        end else begin
          check("m_tdata", m_tdata, sb[0]);
          if (m_tready) begin
            $display("sample %0d data=%h", nsamp, m_tdata);
            nsamp++;
            acc.push_back(m_tdata);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic seg(input logic [15:0] div, input logic [31:0] inc);
    enable = 1'b0;
    m_tready = 1'b1;
    repeat (6) step();
    acc.delete();
    clk_div = div;
    phase_inc = inc;
    enable = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (m_tvalid) return;
      step();
    end
    check(tag, m_tvalid, 1);
  endtask

  task automatic chk_acc(input string tag, input int k, input logic [15:0] exp);
    if (acc.size() <= k) check({tag, "_count"}, acc.size(), k + 1);
    else check(tag, acc[k], exp);
  endtask

  initial begin
    repeat (3) step();
    chk_on = 1'b1;
    ARESET = 1'b0;

    // Reset while a sample is held
    seg(16'd9, 32'h0040_0000);
    wait_valid("hold_timeout");
    m_tready = 1'b0;
    step();
    step();
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_overrun", overrun, 0);
    step();
    ARESET = 1'b0;

    // Basic stepping: addresses 0,1,2
    seg(16'd9, 32'h0040_0000);
    repeat (45) step();
`ifdef SENO_QUARTER_WAVE_EN
    chk_acc("step0", 0, 16'h0000); chk_acc("step1", 1, 16'h0001); chk_acc("step2", 2, 16'h0002);
`else
    chk_acc("step0", 0, 16'h1234); chk_acc("step1", 1, 16'h1295); chk_acc("step2", 2, 16'h12F6);
`endif

    // Half-turn increment: addresses 0,512,0
    seg(16'd9, 32'h8000_0000);
    repeat (45) step();
`ifdef SENO_QUARTER_WAVE_EN
    chk_acc("wrap0", 0, 16'h0000); chk_acc("wrap1", 1, 16'h0000); chk_acc("wrap2", 2, 16'h0000);
`else
    chk_acc("wrap0", 0, 16'h1234); chk_acc("wrap1", 1, 16'hD434); chk_acc("wrap2", 2, 16'h1234);
`endif

    // Backpressure: two ticks dropped while stalled
    seg(16'd9, 32'h0040_0000);
    repeat (15) step();
    wait_valid("bp_timeout");
    m_tready = 1'b0;
    repeat (25) step();
    check("bp_overrun", overrun, 1);
    m_tready = 1'b1;
    repeat (30) step();
    chk_acc("bp_before", 1, exp_data(10'd1));
    chk_acc("bp_after", 2, exp_data(10'd4));

    // Max sustainable rate, then one cycle too fast
    seg(16'd3, 32'h0040_0000);
    repeat (60) step();
    check("rate3_overrun", overrun, 0);
    check("rate3_count", acc.size(), 14);
    seg(16'd2, 32'h0040_0000);
    repeat (60) step();
    check("rate2_overrun", overrun, 1);

    // Enable dropped while a sample is pending
    seg(16'd2, 32'h0040_0000);
    repeat (10) step();
    wait_valid("drop_timeout");
    m_tready = 1'b0;
    enable = 1'b0;
    repeat (5) step();
    check("drop_hold", m_tvalid, 1);
    m_tready = 1'b1;
    step();
    step();
    check("drop_idle", m_tvalid, 0);
    acc.delete();
    clk_div = 16'd9;
    enable = 1'b1;
    repeat (20) step();
    check("reen_overrun", overrun, 0);
    chk_acc("reen_first", 0, exp_data(10'd0));

    // Quadrant folding cases
    seg(16'd9, 32'h4140_0000);
    repeat (30) step();
`ifdef SENO_QUARTER_WAVE_EN
    chk_acc("q1_sample", 1, 16'h00FA);
`else
    chk_acc("q1_sample", 1, 16'h7519);
`endif
    seg(16'd9, 32'hC140_0000);
    repeat (30) step();
`ifdef SENO_QUARTER_WAVE_EN
    chk_acc("q3_sample", 1, 16'hFF06);
`else
    chk_acc("q3_sample", 1, 16'h3719);
`endif

    enable = 1'b0;
    repeat (6) step();
    check("sb_drained", sb.size(), 0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
